// File: rtl/pc_stack_seq_if.sv
// pc_stack_seq_if: sequencer bus; master drives stall/jump/call/ret controls and target, slave returns prog_ctr and stack status
interface pc_stack_seq_if #(
  parameter int D = 12,
  parameter int STK_DEPTH = 4
);
  localparam int CW = $clog2(STK_DEPTH + 1);
  logic stall;
  logic reljump_en;
  logic absjump_en;
  logic call_en;
  logic ret_en;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic [CW-1:0] stk_count;
  logic stk_full;
  logic stk_empty;
  logic stk_err;
  modport master (
    output stall, reljump_en, absjump_en, call_en, ret_en, target,
    input prog_ctr, stk_count, stk_full, stk_empty, stk_err
  );
  modport slave (
    input stall, reljump_en, absjump_en, call_en, ret_en, target,
    output prog_ctr, stk_count, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/pc_stack_seq.sv
// pc_stack_seq: PC sequencer with return-address stack; ports clk, reset (async high), bus (controls in, prog_ctr/stack status out)
module pc_stack_seq #(
  parameter int D = 12,
  parameter int STK_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  pc_stack_seq_if.slave bus
);
  localparam int CW = $clog2(STK_DEPTH + 1);
  logic [D-1:0] pc_q, pc_d, pc_inc, top;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, full, empty, do_ret, do_call, push, pop, fault;
  logic [D-1:0] stk_q [STK_DEPTH];
  always_comb begin
    full = cnt_q == CW'(STK_DEPTH);
    empty = cnt_q == '0;
    pc_inc = pc_q + 1'b1;
    top = '0;
    for (int i = 0; i < STK_DEPTH; i++) top = (cnt_q == CW'(i + 1)) ? stk_q[i] : top;
    do_ret = !bus.stall && bus.ret_en;
    do_call = !bus.stall && !bus.ret_en && bus.call_en;
    pop = do_ret && !empty;
    push = do_call && !full;
    fault = (do_ret && empty) || (do_call && full);
    pc_d = bus.stall ? pc_q :
           bus.ret_en ? (empty ? pc_inc : top) :
           bus.call_en ? (full ? pc_inc : bus.target) :
           bus.absjump_en ? bus.target :
           bus.reljump_en ? pc_q + bus.target :
           pc_inc;
    cnt_d = pop ? cnt_q - 1'b1 : push ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q || fault;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < STK_DEPTH; i++) if (!reset && push && cnt_q == CW'(i)) stk_q[i] <= pc_inc;
  end
  assign bus.prog_ctr = pc_q;
  assign bus.stk_count = cnt_q;
  assign bus.stk_full = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err = err_q;
endmodule
